// File: rtl/fifo_sc_mode_pkg.sv
// Shared constants for the single-clock FIFO.
// Read-mode selectors for the fwft parameter.
package fifo_sc_mode_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/fifo_sc_mode_dpram_sc.sv
// Simple dual-port RAM, one clock.
// Registered write, asynchronous read.
module dpram_sc #(
  parameter int dta_width  = 8,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [dta_width-1:0]  wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [dta_width-1:0]  rdata
);

  logic [dta_width-1:0] mem [1<<addr_width];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc_mode.sv
// Single-clock FIFO, standard or first-word-fall-through read.
// All flags and level are registered from next-state values.
module fifo_sc_mode
  import fifo_sc_mode_pkg::*;
#(
  parameter int dta_width         = 8,
  parameter int addr_width        = 8,
  parameter int prog_empty_thresh = 1,
  parameter int prog_full_thresh  = 1,
  parameter int fwft              = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [dta_width-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  prog_full,
  input  logic                  rd_en,
  output logic [dta_width-1:0]  dout,
  output logic                  empty,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_empty,
  output logic [addr_width:0]   level
);

  localparam int DEPTH = 1 << addr_width;
  localparam int PW = addr_width + 1;
  localparam bit IS_FWFT = (fwft == FIFO_MODE_FWFT);

  if (prog_empty_thresh > DEPTH || prog_full_thresh > DEPTH) begin : g_bad_thresh
    $error("fifo_sc_mode: threshold exceeds DEPTH");
  end

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_d, rptr_d;
  logic [PW-1:0] cnt_d, level_d;
  logic ram_empty;
  logic wr_acc, rd_ram;
  logic valid_d, udf_d;
  logic full_d;
  logic [dta_width-1:0] ram_rd;

  dpram_sc #(
    .dta_width (dta_width),
    .addr_width(addr_width)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & ~clr),
    .waddr(wptr[addr_width-1:0]),
    .wdata(din),
    .raddr(rptr[addr_width-1:0]),
    .rdata(ram_rd)
  );

  // In fwft mode the RAM refills the output register whenever it is free
  always_comb begin
    wr_acc  = wr_en & ~full;
    rd_ram  = rd_en & ~ram_empty;
    valid_d = rd_ram;
    udf_d   = rd_en & ram_empty;
    if (IS_FWFT) begin
      rd_ram  = ~ram_empty & (~valid | rd_en);
      valid_d = rd_ram | (valid & ~rd_en);
      udf_d   = rd_en & ~valid;
    end
    wptr_d = wptr + PW'(wr_acc);
    rptr_d = rptr + PW'(rd_ram);
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      valid_d = 1'b0;
    end
    cnt_d   = wptr_d - rptr_d;
    level_d = IS_FWFT ? cnt_d + PW'(valid_d) : cnt_d;
    full_d  = (wptr_d[addr_width] != rptr_d[addr_width]) &&
              (wptr_d[addr_width-1:0] == rptr_d[addr_width-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_empty  <= 1'b1;
      full       <= 1'b0;
      empty      <= 1'b1;
      valid      <= 1'b0;
      level      <= '0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      dout       <= '0;
    end else begin
      wptr       <= wptr_d;
      rptr       <= rptr_d;
      ram_empty  <= (wptr_d == rptr_d);
      full       <= full_d;
      empty      <= IS_FWFT ? ~valid_d : (wptr_d == rptr_d);
      valid      <= valid_d;
      level      <= level_d;
      prog_full  <= cnt_d >= PW'(DEPTH - prog_full_thresh);
      prog_empty <= level_d <= PW'(prog_empty_thresh);
      wr_ack     <= ~clr & wr_acc;
      overflow   <= ~clr & wr_en & full;
      underflow  <= ~clr & udf_d;
      if (rd_ram && !clr) dout <= ram_rd;
    end
  end

endmodule

// File: tb/tb_fifo_sc_mode.sv
// Scoreboard bench: standard and fwft instances on shared stimulus.
// Queue model predicts flags and read data for both.
module tb_fifo_sc_mode;

  localparam int DEPTH = 4;

  logic clk, rst, clr, wr_en, rd_en;
  logic [7:0] din;

  logic [7:0] s_dout, f_dout;
  logic [2:0] s_level, f_level;
  logic s_full, s_wr_ack, s_overflow, s_prog_full;
  logic s_empty, s_valid, s_underflow, s_prog_empty;
  logic f_full, f_wr_ack, f_overflow, f_prog_full;
  logic f_empty, f_valid, f_underflow, f_prog_empty;

  fifo_sc_mode #(
    .dta_width(8), .addr_width(2),
    .prog_empty_thresh(1), .prog_full_thresh(1), .fwft(0)
  ) u_std (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en),
    .full(s_full), .wr_ack(s_wr_ack), .overflow(s_overflow),
    .prog_full(s_prog_full), .rd_en(rd_en), .dout(s_dout),
    .empty(s_empty), .valid(s_valid), .underflow(s_underflow),
    .prog_empty(s_prog_empty), .level(s_level)
  );

  fifo_sc_mode #(
    .dta_width(8), .addr_width(2),
    .prog_empty_thresh(1), .prog_full_thresh(1), .fwft(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en),
    .full(f_full), .wr_ack(f_wr_ack), .overflow(f_overflow),
    .prog_full(f_prog_full), .rd_en(rd_en), .dout(f_dout),
    .empty(f_empty), .valid(f_valid), .underflow(f_underflow),
    .prog_empty(f_prog_empty), .level(f_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en;

  logic [7:0] sq[$], fq[$], exp_s[$], exp_f[$];
  bit fv;
  logic [7:0] last_s;
  bit es_valid, es_wack, es_ovf, es_udf;
  bit ef_wack, ef_ovf, ef_udf;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete(); fq.delete(); exp_s.delete(); exp_f.delete();
    fv = 0; last_s = 8'h00;
    es_valid = 0; es_wack = 0; es_ovf = 0; es_udf = 0;
    ef_wack = 0; ef_ovf = 0; ef_udf = 0;
  endtask

  // Applies the inputs the DUTs just sampled on this rising edge.
  task automatic model_step();
    int ss, fs;
    bit s_wr, s_rd, f_wr, f_ld;
    if (!rst) begin
      model_reset();
      return;
    end
    es_valid = 0; es_wack = 0; es_ovf = 0; es_udf = 0;
    ef_wack = 0; ef_ovf = 0; ef_udf = 0;
    if (clr) begin
      sq.delete(); fq.delete(); exp_s.delete(); exp_f.delete();
      fv = 0;
      return;
    end
    ss = sq.size();
    fs = fq.size();
    s_wr = wr_en && ss < DEPTH;
    s_rd = rd_en && ss > 0;
    es_wack = s_wr;
    es_ovf = wr_en && ss == DEPTH;
    es_udf = rd_en && ss == 0;
    es_valid = s_rd;
    if (s_rd) exp_s.push_back(sq.pop_front());
    if (s_wr) sq.push_back(din);
    f_wr = wr_en && fs < DEPTH;
    ef_wack = f_wr;
    ef_ovf = wr_en && fs == DEPTH;
    ef_udf = rd_en && !fv;
    f_ld = fs > 0 && (!fv || rd_en);
    if (rd_en && fv) fv = 0;
    if (f_ld) begin
      exp_f.push_back(fq.pop_front());
      fv = 1;
    end
    if (f_wr) fq.push_back(din);
  endtask

  task automatic check_reset_vals();
    chk("rst_s_level", s_level, 0);
    chk("rst_s_full", s_full, 0);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_prog_empty", s_prog_empty, 1);
    chk("rst_s_prog_full", s_prog_full, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_wr_ack", s_wr_ack, 0);
    chk("rst_s_overflow", s_overflow, 0);
    chk("rst_s_underflow", s_underflow, 0);
    chk("rst_s_dout", s_dout, 0);
    chk("rst_f_level", f_level, 0);
    chk("rst_f_full", f_full, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_prog_empty", f_prog_empty, 1);
    chk("rst_f_prog_full", f_prog_full, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_wr_ack", f_wr_ack, 0);
    chk("rst_f_overflow", f_overflow, 0);
    chk("rst_f_underflow", f_underflow, 0);
    chk("rst_f_dout", f_dout, 0);
  endtask

  // Monitor: compares flags and pops the scoreboard on DUT output.
  always @(negedge clk) begin
    int fl;
    if (mon_en) begin
      chk("s_level", s_level, sq.size());
      chk("s_full", s_full, sq.size() == DEPTH);
      chk("s_empty", s_empty, sq.size() == 0);
      chk("s_prog_full", s_prog_full, sq.size() >= DEPTH - 1);
      chk("s_prog_empty", s_prog_empty, sq.size() <= 1);
      chk("s_valid", s_valid, es_valid);
      chk("s_wr_ack", s_wr_ack, es_wack);
      chk("s_overflow", s_overflow, es_ovf);
      chk("s_underflow", s_underflow, es_udf);
      fl = fq.size() + int'(fv);
      chk("f_level", f_level, fl);
      chk("f_full", f_full, fq.size() == DEPTH);
      chk("f_empty", f_empty, !fv);
      chk("f_valid", f_valid, fv);
      chk("f_prog_full", f_prog_full, fq.size() >= DEPTH - 1);
      chk("f_prog_empty", f_prog_empty, fl <= 1);
      chk("f_wr_ack", f_wr_ack, ef_wack);
      chk("f_overflow", f_overflow, ef_ovf);
      chk("f_underflow", f_underflow, ef_udf);
      if (s_valid) begin
        chk("s_sb_pending", exp_s.size() > 0, 1);
        if (exp_s.size() > 0) last_s = exp_s.pop_front();
        chk("s_dout", s_dout, last_s);
      end else begin
        chk("s_dout_hold", s_dout, last_s);
      end
      if (f_valid) begin
        chk("f_sb_pending", exp_f.size() > 0, 1);
        if (exp_f.size() > 0) begin
          chk("f_dout", f_dout, exp_f[0]);
          if (rd_en && !clr) void'(exp_f.pop_front());
        end
      end
    end
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit c);
    @(posedge clk);
    model_step();
    #1;
    wr_en = w; rd_en = r; din = d; clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    model_step();
    #1;
    wr_en = 0; rd_en = 0; clr = 0;
    #2;
    mon_en = 0;
    rst = 0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    mon_en = 1;
  endtask

  initial begin
    logic [7:0] wv [5];
    int wp;
    wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 0; clr = 0; wr_en = 0; rd_en = 0; din = 8'h00;
    mon_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1;
    mon_en = 1;

    // fill past full, then drain, then read on empty
    for (int i = 0; i < 5; i++) step(1, 0, wv[i], 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);
    idle(1);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    idle(2);
    step(0, 0, 8'h00, 1);
    idle(2);

    // single word into empty, then pop
    step(1, 0, 8'hA5, 0);
    idle(2);
    step(0, 1, 8'h00, 0);
    idle(2);

    // five writes then continuous pops
    for (int i = 0; i < 5; i++) step(1, 0, 8'h60 + 8'(i), 0);
    idle(1);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0);
    idle(2);

    // flush with a concurrent write
    step(1, 0, 8'h71, 0);
    step(1, 0, 8'h72, 0);
    step(1, 0, 8'h73, 1);
    idle(2);
    step(0, 1, 8'h00, 0);
    idle(2);

    // simultaneous read and write at various fill levels
    for (int i = 0; i < 3; i++) step(1, 0, 8'h80 + 8'(i), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 8'h90 + 8'(i), 0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 1) ? 30 : 75;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           8'($urandom_range(0, 255)), $urandom_range(0, 99) < 2);
    end
    idle(2);
    step(0, 0, 8'h00, 1);
    idle(1);

    // asynchronous reset at level 3
    step(1, 0, 8'hB1, 0);
    step(1, 0, 8'hB2, 0);
    step(1, 0, 8'hB3, 0);
    mid_reset();
    step(1, 0, 8'hC3, 0);
    idle(2);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    idle(3);

    @(negedge clk);
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
